// File: rtl/timer_sched_pkg.sv
// Shared definitions for the timer scheduler: state encodings and defaults.
// Imported by the scheduler top level.
package timer_sched_pkg;

  typedef enum logic [1:0] {
    SCHD_IDLE_S  = 2'd0,
    SCHD_START_S = 2'd1,
    SCHD_WAIT_S  = 2'd2
  } schd_state_t;

  localparam int SCHD_NUM_REQ  = 4;
  localparam int SCHD_WDOG_MAX = 2**22;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of pending,
// scanning from last+1 and wrapping.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] pending,
  input  logic [W-1:0] last,
  output logic         valid,
  output logic [W-1:0] index
);

  int j;

  always_comb begin
    valid = 1'b0;
    index = '0;
    j     = 0;
    for (int i = 1; i <= N; i++) begin
      j = int'(last) + i;
      if (j >= N) j = j - N;
      if (!valid && pending[j]) begin
        valid = 1'b1;
        index = W'(j);
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Shares one expiry timer among NUM_REQ requesters, round-robin,
// with a watchdog that aborts runs whose expiry never comes.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter  int NUM_REQ  = SCHD_NUM_REQ,
  parameter  int WDOG_MAX = SCHD_WDOG_MAX,
  localparam int ID_W     = $clog2(NUM_REQ),
  localparam int WDOG_W   = $clog2(WDOG_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] done,
  output logic               err,
  output logic               busy,
  output logic [ID_W-1:0]    grant_id,
  output logic               tmr_start,
  input  logic               tmr_pulse
);

  schd_state_t        state, state_n;
  logic [NUM_REQ-1:0] pending, pending_n;
  logic [ID_W-1:0]    last_grant, last_n;
  logic [ID_W-1:0]    grant_n;
  logic [WDOG_W-1:0]  wdog, wdog_n;
  logic [NUM_REQ-1:0] done_n;
  logic               err_n;
  logic               start_n;
  logic               pick_vld;
  logic [ID_W-1:0]    pick_idx;

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_pick (
    .pending (pending),
    .last    (last_grant),
    .valid   (pick_vld),
    .index   (pick_idx)
  );

  assign busy = (state != SCHD_IDLE_S);

  always_comb begin
    state_n   = state;
    pending_n = pending | req;
    last_n    = last_grant;
    grant_n   = grant_id;
    wdog_n    = wdog;
    done_n    = '0;
    err_n     = 1'b0;
    start_n   = 1'b0;
    case (state)
      SCHD_IDLE_S: begin
        if (pick_vld) begin
          grant_n   = pick_idx;
          // a fresh pulse on the granted line re-queues it
          pending_n = (pending & ~(NUM_REQ'(1) << pick_idx)) | req;
          state_n   = SCHD_START_S;
        end
      end
      SCHD_START_S: begin
        start_n = 1'b1;
        wdog_n  = '0;
        state_n = SCHD_WAIT_S;
      end
      SCHD_WAIT_S: begin
        if (tmr_pulse) begin
          done_n  = NUM_REQ'(1) << grant_id;
          last_n  = grant_id;
          state_n = SCHD_IDLE_S;
        end else if (wdog == WDOG_W'(WDOG_MAX - 1)) begin
          err_n   = 1'b1;
          last_n  = grant_id;
          state_n = SCHD_IDLE_S;
        end else begin
          wdog_n = wdog + WDOG_W'(1);
        end
      end
      default: state_n = SCHD_IDLE_S;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SCHD_IDLE_S;
      pending    <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      grant_id   <= '0;
      wdog       <= '0;
      done       <= '0;
      err        <= 1'b0;
      tmr_start  <= 1'b0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      last_grant <= last_n;
      grant_id   <= grant_n;
      wdog       <= wdog_n;
      done       <= done_n;
      err        <= err_n;
      tmr_start  <= start_n;
    end
  end

endmodule
